wb_host_master: RTL and testbench

//  Wishbone (classic, single-transfer) bus master serving the multi-cycle RISC-V core's memory-access interface.

---
 rtl/wb_host_pkg.sv | 34 +++
 rtl/wb_host_master_if.sv | 33 +++
 rtl/wb_timeout_ctr.sv | 30 +++
 rtl/wb_host_master.sv | 137 +++++++++++++
 tb/tb_wb_host_master.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_host_pkg.sv
// Package: wb_host_pkg
// Shared definitions for the Wishbone host master: command op codes,
// response status codes, FSM state encoding and the field layout of the
// 34-bit command/response words.
package wb_host_pkg;

   localparam int WORD_W = 34;
   localparam int OP_HI  = 33;
   localparam int OP_LO  = 32;
   localparam int PAY_HI = 31;
   localparam int PAY_LO = 0;

   localparam logic [1:0] OP_READ    = 2'b00;
   localparam logic [1:0] OP_WR_ADDR = 2'b01;
   localparam logic [1:0] OP_WR_DATA = 2'b10;

   localparam logic [1:0] ST_RD_OK   = 2'b00;
   localparam logic [1:0] ST_WR_OK   = 2'b01;
   localparam logic [1:0] ST_BUS_ERR = 2'b10;
   localparam logic [1:0] ST_PROTO   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_WDATA = 2'b01,
      S_BUS   = 2'b10,
      S_RESP  = 2'b11
   } state_t;

   function automatic logic [WORD_W-1:0] pack_rsp(input logic [1:0] status,
                                                  input logic [31:0] data);
      return {status, data};
   endfunction

endpackage

// File: rtl/wb_host_master_if.sv
// Interface: wb_host_master_if
// Bundles the host command/response handshake and the Wishbone master
// signals of wb_host_master.
//   master modport : the bus master (drives cmd_busy, rsp_*, wb_*_o)
//   slave modport  : the host/slave side (drives cmd_*, wb_*_i)
interface wb_host_master_if;
   logic        cmd_stb;
   logic [33:0] cmd_word;
   logic        cmd_busy;
   logic        rsp_stb;
   logic [33:0] rsp_word;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport master (
      input  cmd_stb, cmd_word, wb_dat_i, wb_ack_i, wb_err_i,
      output cmd_busy, rsp_stb, rsp_word,
             wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );

   modport slave (
      output cmd_stb, cmd_word, wb_dat_i, wb_ack_i, wb_err_i,
      input  cmd_busy, rsp_stb, rsp_word,
             wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );
endinterface

// File: rtl/wb_timeout_ctr.sv
// Module: wb_timeout_ctr
// Bus-cycle watchdog. Cleared by load, advances while en is high, and
// flags expired during the TIMEOUT_CYCLES-th enabled cycle.
// Ports: clk, reset (async active-low), load, en, expired.
module wb_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (load)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_host_master.sv
// Module: wb_host_master
// Classic single-transfer Wishbone master for the core's memory port.
// Accepts 34-bit commands (READ, WR_ADDR + WR_DATA), runs one bus transfer
// per READ / write pair and returns a one-cycle 34-bit response pulse.
// Ports: clk, reset (async active-low), bus (wb_host_master_if.master:
//   cmd_stb/cmd_word/cmd_busy, rsp_stb/rsp_word, wb_* master signals).
// Build option: define WB_TIMEOUT_EN to abort a transfer that sees no
//   ack/err within TIMEOUT_CYCLES bus cycles (response status 11).
module wb_host_master
   import wb_host_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [3:0]  SEL_DEFAULT    = 4'hF
) (
   input  logic             clk,
   input  logic             reset,
   wb_host_master_if.master bus
);

   state_t             state, state_n;
   logic [1:0]         op;
   logic [31:0]        payload;
   logic [31:0]        adr_q, dat_q;
   logic               we_q;
   logic [WORD_W-1:0]  rsp_q, rsp_n;
   logic               ld_rd, ld_wa, ld_wd, rsp_ld;
   logic               timeout_hit;
   logic               tmo_load, tmo_en;

   assign op      = bus.cmd_word[OP_HI:OP_LO];
   assign payload = bus.cmd_word[PAY_HI:PAY_LO];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         adr_q <= '0;
         dat_q <= '0;
         we_q  <= 1'b0;
         rsp_q <= '0;
      end else begin
         state <= state_n;
         if (ld_rd || ld_wa) adr_q <= payload;
         if (ld_rd)          we_q  <= 1'b0;
         if (ld_wd) begin
            dat_q <= payload;
            we_q  <= 1'b1;
         end
         if (rsp_ld)         rsp_q <= rsp_n;
      end
   end

   always_comb begin
      state_n = state;
      ld_rd   = 1'b0;
      ld_wa   = 1'b0;
      ld_wd   = 1'b0;
      rsp_ld  = 1'b0;
      rsp_n   = '0;
      case (state)
         S_IDLE: if (bus.cmd_stb) begin
            if (op == OP_READ) begin
               ld_rd   = 1'b1;
               state_n = S_BUS;
            end else if (op == OP_WR_ADDR) begin
               ld_wa   = 1'b1;
               state_n = S_WDATA;
            end else begin
               rsp_ld  = 1'b1;
               rsp_n   = pack_rsp(ST_PROTO, 32'h0);
               state_n = S_RESP;
            end
         end
         S_WDATA: if (bus.cmd_stb) begin
            if (op == OP_WR_DATA) begin
               ld_wd   = 1'b1;
               state_n = S_BUS;
            end else begin
               rsp_ld  = 1'b1;
               rsp_n   = pack_rsp(ST_PROTO, 32'h0);
               state_n = S_RESP;
            end
         end
         S_BUS: begin
            // err has priority over a simultaneous ack; a completed transfer
            // has priority over a timeout expiring in the same cycle.
            if (bus.wb_err_i) begin
               rsp_ld  = 1'b1;
               rsp_n   = pack_rsp(ST_BUS_ERR, 32'h0);
               state_n = S_RESP;
            end else if (bus.wb_ack_i) begin
               rsp_ld  = 1'b1;
               rsp_n   = we_q ? pack_rsp(ST_WR_OK, 32'h0)
                              : pack_rsp(ST_RD_OK, bus.wb_dat_i);
               state_n = S_RESP;
            end else if (timeout_hit) begin
               rsp_ld  = 1'b1;
               rsp_n   = pack_rsp(ST_PROTO, 32'h0);
               state_n = S_RESP;
            end
         end
         S_RESP:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign tmo_load = ld_rd || ld_wd;
   assign tmo_en   = (state == S_BUS);

`ifdef WB_TIMEOUT_EN
   wb_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .load    (tmo_load),
      .en      (tmo_en),
      .expired (timeout_hit)
   );
`else
   logic unused_tmo;
   assign unused_tmo  = ^{TIMEOUT_CYCLES, tmo_load, tmo_en};
   assign timeout_hit = 1'b0;
`endif

   // Bus strobes and busy are decoded from state alone, so an async reset
   // (state -> IDLE) drops them immediately.
   assign bus.cmd_busy = (state == S_BUS) || (state == S_RESP);
   assign bus.rsp_stb  = (state == S_RESP);
   assign bus.rsp_word = rsp_q;
   assign bus.wb_cyc_o = (state == S_BUS);
   assign bus.wb_stb_o = (state == S_BUS);
   assign bus.wb_we_o  = we_q;
   assign bus.wb_adr_o = adr_q;
   assign bus.wb_dat_o = dat_q;
   assign bus.wb_sel_o = (state == S_BUS) ? SEL_DEFAULT : 4'h0;

endmodule

// File: tb/tb_wb_host_master.sv
// Testbench: tb_wb_host_master
// Directed vector table of complete transfers plus hand-written sequences
// for protocol errors, reset during a transfer and (with WB_TIMEOUT_EN)
// the bus timeout.
module tb_wb_host_master;
   import wb_host_pkg::*;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   wb_host_master_if bus();

   wb_host_master #(
      .TIMEOUT_CYCLES(8),
      .SEL_DEFAULT   (4'hF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        is_wr;
      logic [31:0] adr;
      logic [31:0] dat;
      int          dly;
      logic        ack;
      logic        err;
      logic [33:0] exp_rsp;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [31:0] pl);
      int n;
      n = 0;
      while (bus.cmd_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_busy_bounded", 64'(n < 50), 64'd1);
      bus.cmd_stb  = 1'b1;
      bus.cmd_word = {op, pl};
      @(negedge clk);
      bus.cmd_stb  = 1'b0;
      bus.cmd_word = '0;
   endtask

   task automatic run_vec(input vec_t v);
      if (v.is_wr) begin
         do_cmd(OP_WR_ADDR, v.adr);
         chk("wdata_busy", 64'(bus.cmd_busy), 64'd0);
         chk("wdata_cyc", 64'(bus.wb_cyc_o), 64'd0);
         do_cmd(OP_WR_DATA, v.dat);
      end else begin
         do_cmd(OP_READ, v.adr);
      end
      chk("cyc_latency", 64'(bus.wb_cyc_o), 64'd1);
      chk("stb_eq_cyc", 64'(bus.wb_stb_o), 64'd1);
      chk("we", 64'(bus.wb_we_o), 64'(v.is_wr));
      chk("adr", 64'(bus.wb_adr_o), 64'(v.adr));
      if (v.is_wr) chk("dat_o", 64'(bus.wb_dat_o), 64'(v.dat));
      chk("sel", 64'(bus.wb_sel_o), 64'hF);
      chk("bus_busy", 64'(bus.cmd_busy), 64'd1);
      for (int i = 0; i < v.dly; i++) begin
         @(negedge clk);
         chk("cyc_wait", 64'(bus.wb_cyc_o), 64'd1);
      end
      bus.wb_ack_i = v.ack;
      bus.wb_err_i = v.err;
      bus.wb_dat_i = v.is_wr ? 32'hBAD0BAD0 : v.dat;
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      bus.wb_dat_i = 32'h5555AAAA;
      chk("rsp_stb", 64'(bus.rsp_stb), 64'd1);
      chk("rsp_word", 64'(bus.rsp_word), 64'(v.exp_rsp));
      chk("cyc_drop", 64'(bus.wb_cyc_o), 64'd0);
      chk("resp_busy", 64'(bus.cmd_busy), 64'd1);
      @(negedge clk);
      chk("rsp_stb_1cyc", 64'(bus.rsp_stb), 64'd0);
      chk("rsp_hold", 64'(bus.rsp_word), 64'(v.exp_rsp));
      chk("idle_busy", 64'(bus.cmd_busy), 64'd0);
   endtask

   initial begin
      int n;
      n_chk  = 0;
      n_pass = 0;
      vecs[0] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, 34'h0_DEAD_BEEF};
      vecs[1] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 0, 1'b1, 1'b0, 34'h1_0000_0000};
      vecs[2] = '{1'b0, 32'h0000_0020, 32'hCAFE_F00D, 1, 1'b1, 1'b1, 34'h2_0000_0000};
      vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0001, 0, 1'b1, 1'b0, 34'h0_0000_0001};
      vecs[4] = '{1'b1, 32'h8000_0000, 32'hA5A5_5A5A, 3, 1'b1, 1'b0, 34'h1_0000_0000};
      vecs[5] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 1, 1'b0, 1'b1, 34'h2_0000_0000};
      vecs[6] = '{1'b0, 32'h0000_0008, 32'h1111_2222, 0, 1'b0, 1'b1, 34'h2_0000_0000};
      vecs[7] = '{1'b1, 32'h0000_0C00, 32'h0BAD_CAFE, 0, 1'b1, 1'b1, 34'h2_0000_0000};

      bus.cmd_stb  = 1'b0;
      bus.cmd_word = '0;
      bus.wb_dat_i = '0;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
      chk("rst_stb", 64'(bus.wb_stb_o), 64'd0);
      chk("rst_rsp_stb", 64'(bus.rsp_stb), 64'd0);
      chk("rst_rsp_word", 64'(bus.rsp_word), 64'd0);
      chk("rst_busy", 64'(bus.cmd_busy), 64'd0);
      chk("rst_we_adr_dat_sel",
          64'({bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o}), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // WR_ADDR followed by READ: protocol error, no bus cycle.
      do_cmd(OP_WR_ADDR, 32'h0000_0200);
      do_cmd(OP_READ, 32'h0000_0300);
      chk("proto_wa_rd_cyc", 64'(bus.wb_cyc_o), 64'd0);
      chk("proto_wa_rd_stb", 64'(bus.rsp_stb), 64'd1);
      chk("proto_wa_rd_rsp", 64'(bus.rsp_word), 64'h3_0000_0000);
      @(negedge clk);
      chk("proto_wa_rd_1cyc", 64'(bus.rsp_stb), 64'd0);
      run_vec('{1'b0, 32'h0000_0300, 32'h7654_3210, 1, 1'b1, 1'b0, 34'h0_7654_3210});

      // WR_DATA and reserved op straight from IDLE.
      do_cmd(OP_WR_DATA, 32'h1111_1111);
      chk("proto_wd_rsp", 64'({bus.rsp_stb, bus.wb_cyc_o, bus.rsp_word}), {1'b1, 1'b0, 34'h3_0000_0000});
      @(negedge clk);
      do_cmd(2'b11, 32'h2222_2222);
      chk("proto_op11_rsp", 64'({bus.rsp_stb, bus.wb_cyc_o, bus.rsp_word}), {1'b1, 1'b0, 34'h3_0000_0000});
      @(negedge clk);

      // Async reset in the middle of a bus cycle.
      do_cmd(OP_READ, 32'h0000_0040);
      chk("rstbus_cyc_before", 64'(bus.wb_cyc_o), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("rstbus_cyc", 64'(bus.wb_cyc_o), 64'd0);
      chk("rstbus_stb", 64'(bus.wb_stb_o), 64'd0);
      chk("rstbus_rsp_stb", 64'(bus.rsp_stb), 64'd0);
      chk("rstbus_rsp_word", 64'(bus.rsp_word), 64'd0);
      bus.wb_ack_i = 1'b1;
      bus.wb_dat_i = 32'h9999_9999;
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.rsp_stb || bus.wb_cyc_o) n++;
      end
      chk("rstbus_no_resp", 64'(n), 64'd0);
      run_vec(vecs[0]);

`ifdef WB_TIMEOUT_EN
      // Slave never answers: abort after 8 bus cycles, late ack ignored.
      do_cmd(OP_READ, 32'h0000_0080);
      n = 0;
      while (bus.wb_cyc_o && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_cyc_len", 64'(n), 64'd8);
      chk("tmo_rsp_stb", 64'(bus.rsp_stb), 64'd1);
      chk("tmo_rsp_word", 64'(bus.rsp_word), 64'h3_0000_0000);
      @(negedge clk);
      bus.wb_ack_i = 1'b1;
      bus.wb_dat_i = 32'h4444_4444;
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.rsp_stb || bus.wb_cyc_o) n++;
      end
      chk("tmo_late_ack_ignored", 64'(n), 64'd0);
      chk("tmo_rsp_hold", 64'(bus.rsp_word), 64'h3_0000_0000);
      run_vec(vecs[1]);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
